// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty flags, sticky error flags.
// Latency: pop data registered 1 cycle after an accepted pop; 0 cycles with SYNC_FIFO_FWFT_EN.
// Backpressure: push dropped (overflow_o set) when full without a pop; pop ignored when empty.
module sync_fifo_ctrl #(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 1,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              pop_valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o,
  output logic              underflow_o,
  input  logic              err_clr_i
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic              push_ok;
  logic              pop_ok;
  logic              ovf_set;
  logic              unf_set;

  // Explicit wrap so non-power-of-2 depths index only valid entries.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Status flags decode straight from the count register.
  assign count_o        = count_q;
  assign full_o         = (count_q == CNT_W'(DEPTH));
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty_o = (count_q <= CNT_W'(AE_LEVEL));

  // A pop frees a slot in the same cycle, so a full FIFO may accept push+pop together.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign ovf_set = push_i && full_o && !pop_ok;
  assign unf_set = pop_i && empty_o;

  // Occupancy moves by at most one per cycle; simultaneous push+pop leaves it unchanged.
  always_comb begin
    count_nxt = count_q;
    if (push_ok && !pop_ok) begin
      count_nxt = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_nxt = count_q - 1'b1;
    end
  end

  // Pointer, count and sticky error state; a new error in the clear cycle stays set.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      count_q     <= count_nxt;
      overflow_o  <= ovf_set || (overflow_o && !err_clr_i);
      underflow_o <= unf_set || (underflow_o && !err_clr_i);
    end
  end

  // Storage is not reset; entries are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is presented continuously; pop_i acknowledges it.
  assign pop_data_o  = mem[rd_ptr];
  assign pop_valid_o = !empty_o;
`else
  logic [DATA_W-1:0] pop_data_q;
  logic              pop_valid_q;

  // Registered read: head captured on an accepted pop, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      pop_valid_q <= pop_ok;
      if (pop_ok) pop_data_q <= mem[rd_ptr];
    end
  end

  assign pop_data_o  = pop_data_q;
  assign pop_valid_o = pop_valid_q;
`endif

endmodule
